// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state encoding and width helper for the round-robin arbiter
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_search.sv
// rtl/rr_prio_search.sv - rotating priority search, first set request at or after start
module rr_prio_search
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    rot   = N_REQ'({req, req} >> start);
    off   = '0;
    found = 1'b0;
    // downward scan so the lowest set offset is the one left standing
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_arbiter_ack.sv
// rtl/rr_arbiter_ack.sv - round-robin arbiter with ack-held registered grant and optional timeout
module rr_arbiter_ack
  import rr_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = clog2(N_REQ),
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout_pulse
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] last_idx, last_nxt;
  logic [IDX_W-1:0] ptr, start, win_idx, idx_nxt;
  logic [N_REQ-1:0] oh_nxt;
  logic [TO_W-1:0]  cnt, cnt_nxt;
  logic             found, expire, release_g, pulse_nxt;

  assign expire    = (TIMEOUT > 0) && (state == ST_GRANT) && !ack && (cnt == TO_LAST);
  assign release_g = (state == ST_GRANT) && (ack || expire);

  // a released grant rotates the search past itself in the same cycle
  assign ptr   = release_g ? grant_idx : last_idx;
  assign start = (ptr == LAST_RST) ? '0 : ptr + 1'b1;

  rr_prio_search #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_search (
    .req  (req),
    .start(start),
    .idx  (win_idx),
    .found(found)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last_idx;
    idx_nxt   = grant_idx;
    oh_nxt    = grant_onehot;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_GRANT;
          idx_nxt   = win_idx;
          oh_nxt    = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
          cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (release_g) begin
          last_nxt  = grant_idx;
          pulse_nxt = expire;
          cnt_nxt   = '0;
          if (found) begin
            idx_nxt = win_idx;
            oh_nxt  = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
          end else begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            oh_nxt    = '0;
          end
        end else if (TIMEOUT > 0) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      last_idx      <= LAST_RST;
      grant_idx     <= '0;
      grant_onehot  <= '0;
      cnt           <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_idx      <= last_nxt;
      grant_idx     <= idx_nxt;
      grant_onehot  <= oh_nxt;
      cnt           <= cnt_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  assign grant_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_ack.sv
// tb/tb_rr_arbiter_ack.sv - scoreboard bench for rr_arbiter_ack in three configurations
module tb_rr_arbiter_ack;

  typedef struct {
    int dut;
    bit is_to;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] req_a [3];
  logic       ack_a [3];

  logic       gv0, gv1, gv2;
  logic [1:0] gi0, gi1;
  logic [2:0] gi2;
  logic [3:0] oh0, oh1;
  logic [4:0] oh2;
  logic       tp0, tp1, tp2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   prev_v [3];
  bit   prev_a [3];
  int   prev_idx [3];

  rr_arbiter_ack #(.N_REQ(4), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_a[0][3:0]), .ack(ack_a[0]),
    .grant_valid(gv0), .grant_idx(gi0), .grant_onehot(oh0), .timeout_pulse(tp0)
  );

  rr_arbiter_ack #(.N_REQ(4), .TIMEOUT(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_a[1][3:0]), .ack(ack_a[1]),
    .grant_valid(gv1), .grant_idx(gi1), .grant_onehot(oh1), .timeout_pulse(tp1)
  );

  rr_arbiter_ack #(.N_REQ(5), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .rst(rst), .req(req_a[2]), .ack(ack_a[2]),
    .grant_valid(gv2), .grant_idx(gi2), .grant_onehot(oh2), .timeout_pulse(tp2)
  );

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0d required %0d", name, d, act, exp);
    end
  endtask

  task automatic pop(input int d, input bit to, input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d to=%0d actual idx %0d required none", d, to, idx);
    end else begin
      e = sb.pop_front();
      chk("sb_dut", d, d, e.dut);
      chk("sb_kind", d, int'(to), int'(e.is_to));
      chk("sb_idx", d, idx, e.idx);
    end
  endtask

  task automatic mon(input int d, input int n, input logic v, input int idx, input int oh,
                     input logic a, input logic p);
    if (!v) begin
      chk("idle_idx", d, idx, 0);
      chk("idle_onehot", d, oh, 0);
    end else begin
      chk("onehot", d, oh, 1 << idx);
      chk("idx_range", d, int'(idx < n), 1);
      if (prev_v[d] && !prev_a[d] && !p) chk("hold", d, idx, prev_idx[d]);
    end
    if (p) begin
      chk("pulse_valid", d, int'(v), 1);
      pop(d, 1'b1, idx);
    end
    if (v && a) pop(d, 1'b0, idx);
    prev_v[d]   = v;
    prev_a[d]   = a;
    prev_idx[d] = idx;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, 4, gv0, int'(gi0), int'(oh0), ack_a[0], tp0);
      mon(1, 4, gv1, int'(gi1), int'(oh1), ack_a[1], tp1);
      mon(2, 5, gv2, int'(gi2), int'(oh2), ack_a[2], tp2);
    end else begin
      for (int k = 0; k < 3; k++) begin
        prev_v[k] = 1'b0;
        prev_a[k] = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic gv_of(input int d);
    case (d)
      0:       return gv0;
      1:       return gv1;
      default: return gv2;
    endcase
  endfunction

  task automatic push(input int d, input int idx, input bit to = 1'b0);
    sb.push_back('{dut: d, is_to: to, idx: idx});
  endtask

  task automatic wait_valid(input int d);
    int t;
    t = 0;
    while (!gv_of(d) && t < 20) begin
      tick();
      t++;
    end
    chk("wait_valid", d, int'(gv_of(d)), 1);
  endtask

  task automatic burst(input int d, input int n);
    wait_valid(d);
    ack_a[d] = 1'b1;
    tick(n);
    ack_a[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_a[k] = '0;
      ack_a[k] = 1'b0;
    end
    tick(2);
    chk("rst_valid", 0, int'(gv0), 0);
    chk("rst_idx", 0, int'(gi0), 0);
    chk("rst_onehot", 0, int'(oh0), 0);
    chk("rst_pulse", 1, int'(tp1), 0);
    chk("rst_valid", 2, int'(gv2), 0);
    rst = 1'b1;
    tick();

    // reset while a grant is held
    req_a[0] = 5'b01111;
    tick(2);
    chk("grant_before_rst", 0, int'(gv0), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 0, int'(gv0), 0);
    chk("async_rst_onehot", 0, int'(oh0), 0);
    tick();
    rst = 1'b1;

    // full rotation back-to-back from the reset pointer
    push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(0, 0);
    burst(0, 5);

    // grant 1 held through request changes
    req_a[0] = 5'b00110;
    tick(5);
    req_a[0] = 5'b00000;
    tick(2);
    chk("held_idx", 0, int'(gi0), 1);
    push(0, 1);
    burst(0, 1);
    chk("idle_after_ack", 0, int'(gv0), 0);

    // move pointer to 2, then skip and wrap
    req_a[0] = 5'b00100;
    wait_valid(0);
    req_a[0] = 5'b00000;
    push(0, 2);
    burst(0, 1);
    req_a[0] = 5'b00011;
    push(0, 0);
    push(0, 3);
    wait_valid(0);
    req_a[0] = 5'b01000;
    burst(0, 1);
    req_a[0] = 5'b00000;
    burst(0, 1);
    chk("idle_after_wrap", 0, int'(gv0), 0);

    // idle cycles must not move the pointer (last=3)
    tick(4);
    req_a[0] = 5'b01111;
    push(0, 0);
    wait_valid(0);
    req_a[0] = 5'b00000;
    burst(0, 1);

    // single requester re-granted
    req_a[0] = 5'b00010;
    push(0, 1); push(0, 1); push(0, 1);
    burst(0, 3);
    req_a[0] = 5'b00000;
    push(0, 1);
    burst(0, 1);
    chk("idle_single", 0, int'(gv0), 0);

    // timeout revokes grant 0 after three cycles, grant 2 follows
    req_a[1] = 5'b00101;
    wait_valid(1);
    push(1, 2, 1'b1);
    lat = 0;
    while (!tp1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("to_latency", 1, lat, 3);
    // ack on the expiry edge of grant 2 beats the timeout
    tick(2);
    ack_a[1] = 1'b1;
    push(1, 2);
    tick();
    ack_a[1] = 1'b0;
    chk("after_ack_idx", 1, int'(gi1), 0);
    req_a[1] = 5'b00000;
    push(1, 0);
    burst(1, 1);
    tick(5);
    chk("idle_to", 1, int'(gv1), 0);

    // five requesters, alternating 0 and 4
    req_a[2] = 5'b10001;
    push(2, 0); push(2, 4); push(2, 0); push(2, 4);
    burst(2, 4);
    req_a[2] = 5'b00000;
    push(2, 0);
    burst(2, 1);
    chk("idle_n5", 2, int'(gv2), 0);
    tick(4);
    req_a[2] = 5'b10001;
    push(2, 4);
    wait_valid(2);
    req_a[2] = 5'b00000;
    burst(2, 1);
    chk("idle_n5_end", 2, int'(gv2), 0);

    tick(3);
    chk("sb_empty", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
